fetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the instruction cache.
- Owns the program counter and drives the cache's req/addr request interface, collecting each valid/data response.
- Buffers fetched words in a small FIFO and presents {pc, instruction} to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes stale fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: FSM state encoding and shared constants for the instruction fetch unit.
package fetch_pkg;

    // Request sequencing states: IDLE decides whether to fetch, REQ waits for the
    // cache, RELEASE drops the request for one cycle so the cache can go idle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } fetch_state_t;

    // PC loaded at reset unless the instantiation overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam int INST_INCR = 4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding {pc, instruction} entries for decode.
// Push and pop may happen together at any occupancy; flush empties it and wins
// over both. No bypass path: a word pushed into an empty FIFO shows up one cycle later.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 2,
    parameter int LOG2_DEPTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    input  logic              i_flush,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full
);

    logic [DATA_W-1:0]     r_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] r_wr_ptr;
    logic [LOG2_DEPTH-1:0] r_rd_ptr;
    logic [LOG2_DEPTH:0]   r_count;

    logic w_empty;
    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (LOG2_DEPTH + 1)'(DEPTH));

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_do_pop  = i_pop && !w_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!w_full || w_do_pop);

    assign o_valid = !w_empty;
    assign o_full  = w_full;
    // Drive zeros while empty so decode never sees stale storage contents.
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];

    // Entry storage: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + LOG2_DEPTH'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + LOG2_DEPTH'(1);
            end
        end
    end

    // Occupancy tracking, LOG2_DEPTH+1 bits so that "full" is representable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (LOG2_DEPTH + 1)'(1);
                2'b01:   r_count <= r_count - (LOG2_DEPTH + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the instruction cache.
// Owns the PC, issues one cache request at a time (req held until valid, then
// dropped for one cycle), buffers returned words in fetch_fifo and hands
// {pc, instruction} to decode. Redirects from execute flush the buffer and
// discard any word still in flight.
// Optional build macro FETCH_TIMEOUT_EN: adds a watchdog that raises a sticky
// fetch_error after TIMEOUT_CYCLES consecutive cycles waiting in REQ.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    WORD_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter int                    FIFO_DEPTH      = 2,
    parameter int                    LOG2_FIFO_DEPTH = 1,
    parameter int                    TIMEOUT_CYCLES  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  cache_req,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_valid,
    input  logic [WORD_WIDTH-1:0] cache_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [WORD_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    output logic                  fetch_error
);

    localparam int ENTRY_W = ADDR_WIDTH + WORD_WIDTH;

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_fetch_addr;
    logic                  r_discard;

    logic [ADDR_WIDTH-1:0] w_redirect_target;
    logic [ADDR_WIDTH-1:0] w_pc_incr;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_head_valid;
    logic [ENTRY_W-1:0]    w_head;
    logic [ENTRY_W-1:0]    w_push_entry;

    // Redirect targets are word aligned; the two low bits are dropped.
    assign w_redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
    assign w_pc_incr         = r_pc + ADDR_WIDTH'(INST_INCR);

    // The outstanding request is visible exactly while sitting in REQ.
    assign cache_req  = (r_state == REQ);
    assign cache_addr = r_fetch_addr;

    // Next-state and per-cycle strobes for the request sequencer.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_full && !redirect_valid) begin
                    w_next_state = REQ;
                    w_issue      = 1'b1;
                end
            end
            REQ: begin
                // The cache cannot abandon a miss, so REQ only exits on a response.
                if (cache_valid) begin
                    w_next_state = RELEASE;
                    w_push       = !r_discard && !redirect_valid;
                end
            end
            RELEASE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Program counter: redirect has priority over the post-response increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (r_state == REQ && cache_valid && !r_discard) begin
            r_pc <= w_pc_incr;
        end
    end

    // Latch the fetch address on issue so it stays stable for the whole request,
    // even if a redirect moves the PC while the cache is still working.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_addr <= RESET_PC;
        end else if (w_issue) begin
            r_fetch_addr <= r_pc;
        end
    end

    // Discard marks an in-flight request made stale by a redirect. A redirect
    // arriving together with the response drops that word directly instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_discard <= 1'b0;
        end else if (r_state == REQ) begin
            if (cache_valid) begin
                r_discard <= 1'b0;
            end else if (redirect_valid) begin
                r_discard <= 1'b1;
            end
        end
    end

    assign w_push_entry = {r_fetch_addr, cache_data};
    assign w_pop        = w_head_valid && inst_ready;

    fetch_fifo #(
        .DATA_W     (ENTRY_W),
        .DEPTH      (FIFO_DEPTH),
        .LOG2_DEPTH (LOG2_FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_valid (w_head_valid),
        .o_data  (w_head),
        .o_full  (w_fifo_full)
    );

    assign inst_valid = w_head_valid;
    assign inst_pc    = w_head[ENTRY_W-1:WORD_WIDTH];
    assign inst_data  = w_head[WORD_WIDTH-1:0];

`ifdef FETCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_fetch_error;

    // Watchdog: count consecutive REQ cycles; the FSM keeps waiting regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_fetch_error <= 1'b0;
        end else begin
            if (r_state != REQ) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TO_LAST) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (r_state == REQ && r_to_cnt == TO_LAST) begin
                r_fetch_error <= 1'b1;
            end
        end
    end

    assign fetch_error = r_fetch_error;
`else
    // Watchdog compiled out: the flag is constant low and TIMEOUT_CYCLES has no effect.
    assign fetch_error = (TIMEOUT_CYCLES > 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks for fetch_unit against a
// program-order model (decode must see pc, pc+4, ... restarting at each redirect
// target, with data equal to the memory image at that pc).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cache_req;
    logic [31:0] cache_addr;
    logic        cache_valid = 1'b0;
    logic [31:0] cache_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready = 1'b0;
    logic        fetch_error;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_WIDTH      (32),
        .WORD_WIDTH      (32),
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (2),
        .LOG2_FIFO_DEPTH (1),
        .TIMEOUT_CYCLES  (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cache_req      (cache_req),
        .cache_addr     (cache_addr),
        .cache_valid    (cache_valid),
        .cache_data     (cache_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_error    (fetch_error)
    );

    int          total = 0;
    int          failed = 0;
    int          cyc, n_acc, n_resp, req_cnt, cur_lat, miss_lat;
    int          n_watch_req, n_watch_acc;
    bit          prev_req, hang, miss_en, rand_lat;
    logic [31:0] prev_addr, exp_pc, miss_addr, watch_addr;
    logic [31:0] req_q[$];
    int          req_cyc[$];
    logic        exp_err;

    // Memory image seen through the cache.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One clock: update the program-order model from the handshakes happening at
    // this edge, then play the cache for the next edge.
    task automatic tick();
        if (redirect_valid) begin
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (inst_valid && inst_ready) begin
            check("stream_pc", {32'd0, inst_pc}, {32'd0, exp_pc});
            check("stream_data", {32'd0, inst_data}, {32'd0, memf(exp_pc)});
            if (exp_pc == watch_addr) n_watch_acc++;
            exp_pc = exp_pc + 32'd4;
            n_acc++;
        end
        if (cache_req && cache_valid) n_resp++;
        @(posedge clk);
        #1;
        cyc++;
        redirect_valid = 1'b0;
        if (cache_req) begin
            if (!prev_req) begin
                req_q.push_back(cache_addr);
                req_cyc.push_back(cyc);
                req_cnt = 0;
                if (miss_en && cache_addr == miss_addr) cur_lat = miss_lat;
                else if (rand_lat) cur_lat = int'($urandom_range(1, 4));
                else cur_lat = 1;
            end else begin
                check("addr_hold", {32'd0, cache_addr}, {32'd0, prev_addr});
            end
            req_cnt++;
            if (cache_addr == watch_addr) n_watch_req++;
            cache_valid = !hang && (req_cnt >= cur_lat);
            cache_data  = memf(cache_addr);
        end else begin
            cache_valid = 1'b0;
            cache_data  = '0;
        end
        prev_req  = cache_req;
        prev_addr = cache_addr;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        cache_valid    = 1'b0;
        cache_data     = '0;
        inst_ready     = 1'b0;
        hang           = 1'b0;
        miss_en        = 1'b0;
        rand_lat       = 1'b0;
        miss_lat       = 1;
        miss_addr      = '0;
        watch_addr     = 32'hDEAD_BEE0;
        @(posedge clk);
        @(posedge clk);
        #1;
        req_q.delete();
        req_cyc.delete();
        n_acc = 0; n_resp = 0; n_watch_req = 0; n_watch_acc = 0;
        prev_req = 1'b0; prev_addr = '0; req_cnt = 0; cur_lat = 1; cyc = 0;
        exp_pc = 32'h0;
        rst = 1'b0;
    endtask

    initial begin
`ifdef FETCH_TIMEOUT_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // Reset values while rst is held.
        #3;
        check("rst_cache_req", {63'd0, cache_req}, 64'd0);
        check("rst_cache_addr", {32'd0, cache_addr}, 64'd0);
        check("rst_inst_valid", {63'd0, inst_valid}, 64'd0);
        check("rst_inst_data", {32'd0, inst_data}, 64'd0);
        check("rst_inst_pc", {32'd0, inst_pc}, 64'd0);
        check("rst_fetch_error", {63'd0, fetch_error}, 64'd0);

        // Hits, decode always ready: 0x0, 0x4, 0x8 at one request per 3 cycles.
        do_reset();
        inst_ready = 1'b1;
        repeat (12) tick();
        check("t1_nreq", {63'd0, req_q.size() >= 3}, 64'd1);
        check("t1_addr0", {32'd0, req_q[0]}, 64'h0);
        check("t1_addr1", {32'd0, req_q[1]}, 64'h4);
        check("t1_addr2", {32'd0, req_q[2]}, 64'h8);
        check("t1_period", 64'(req_cyc[1] - req_cyc[0]), 64'd3);
        check("t1_period2", 64'(req_cyc[2] - req_cyc[1]), 64'd3);
        check("t1_accepted", {63'd0, n_acc >= 3}, 64'd1);

        // Decode stalled: two words fill the buffer, then no more requests.
        do_reset();
        repeat (20) tick();
        check("t2_pushes", 64'(n_resp), 64'd2);
        check("t2_req_idle", {63'd0, cache_req}, 64'd0);
        check("t2_valid", {63'd0, inst_valid}, 64'd1);
        check("t2_head_pc", {32'd0, inst_pc}, 64'h0);
        check("t2_head_data", {32'd0, inst_data}, {32'd0, memf(32'h0)});
        req_q.delete();
        inst_ready = 1'b1;
        for (int k = 0; k < 10 && req_q.size() == 0; k++) tick();
        check("t2_resume_seen", {63'd0, req_q.size() != 0}, 64'd1);
        check("t2_resume_addr", {32'd0, req_q[0]}, 64'h8);

        // 20-cycle miss at 0x10: request held, one push only.
        do_reset();
        inst_ready = 1'b1;
        miss_en = 1'b1; miss_addr = 32'h10; miss_lat = 20; watch_addr = 32'h10;
        repeat (50) tick();
        check("t3_req_cycles", 64'(n_watch_req), 64'd20);
        check("t3_single_push", 64'(n_watch_acc), 64'd1);

        // Redirect while the request for 0x20 is pending.
        do_reset();
        inst_ready = 1'b1;
        miss_en = 1'b1; miss_addr = 32'h20; miss_lat = 6; watch_addr = 32'h20;
        for (int k = 0; k < 40 && !(cache_req && cache_addr == 32'h20); k++) tick();
        check("t4_reach_0x20", {63'd0, cache_req && cache_addr == 32'h20}, 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        check("t4_flushed", {63'd0, inst_valid}, 64'd0);
        req_q.delete();
        for (int k = 0; k < 20 && req_q.size() == 0; k++) tick();
        check("t4_next_addr", {32'd0, req_q[0]}, 64'h100);
        for (int k = 0; k < 10 && !inst_valid; k++) tick();
        check("t4_first_pc", {32'd0, inst_pc}, 64'h100);
        check("t4_req_not_aborted", 64'(n_watch_req), 64'd6);
        check("t4_dropped", 64'(n_watch_acc), 64'd0);

        // Redirect coincident with a cache response and a decode pop.
        do_reset();
        miss_en = 1'b1; miss_addr = 32'h4; miss_lat = 3;
        for (int k = 0; k < 20 && !(cache_valid && cache_addr == 32'h4); k++) tick();
        check("t5_response_up", {63'd0, cache_valid && cache_addr == 32'h4}, 64'd1);
        check("t5_head_valid", {63'd0, inst_valid}, 64'd1);
        inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        check("t5_empty", {63'd0, inst_valid}, 64'd0);
        req_q.delete();
        for (int k = 0; k < 20 && req_q.size() == 0; k++) tick();
        check("t5_next_addr", {32'd0, req_q[0]}, 64'h200);
        for (int k = 0; k < 10 && !inst_valid; k++) tick();
        check("t5_first_pc", {32'd0, inst_pc}, 64'h200);

        // Unaligned redirect near the top of the address space; PC wraps to 0.
        do_reset();
        inst_ready = 1'b1;
        for (int k = 0; k < 20 && req_q.size() < 2; k++) tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        req_q.delete();
        for (int k = 0; k < 30 && req_q.size() < 2; k++) tick();
        check("t7_wrap_addr0", {32'd0, req_q[0]}, 64'hFFFF_FFFC);
        check("t7_wrap_addr1", {32'd0, req_q[1]}, 64'h0);

        // Cache never answers: watchdog behaviour depends on the build.
        do_reset();
        inst_ready = 1'b1;
        hang = 1'b1;
        repeat (4) tick();
        check("t6_err_early", {63'd0, fetch_error}, 64'd0);
        repeat (20) tick();
        check("t6_err", {63'd0, fetch_error}, {63'd0, exp_err});
        check("t6_req_held", {63'd0, cache_req}, 64'd1);
        check("t6_addr_held", {32'd0, cache_addr}, 64'h0);
        rst = 1'b1;
        #1;
        check("t6_err_cleared", {63'd0, fetch_error}, 64'd0);

        // Random latencies, decode stalls and redirects against the program-order model.
        do_reset();
        rand_lat = 1'b1;
        for (int i = 0; i < 800; i++) begin
            inst_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom & 32'h0000_0FFF;
            end
            tick();
        end
        check("rand_progress", {63'd0, n_acc > 30}, 64'd1);

        $display("%0d/%0d checks passed", total - failed, total);
        $finish;
    end

endmodule
